// File: rtl/color_pkg.sv
// Shared definitions for the colour mapper: mode encodings, channel slot
// positions inside the packed {R,G,B} palette word, and the reset palette image.
package color_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_DIM    = 2'b10,
      MODE_INVERT = 2'b11
   } mode_e;

   // Channel slot within a {R,G,B} word; red occupies the most significant slot.
   localparam int NUM_CH = 3;
   localparam int CH_R   = 2;
   localparam int CH_G   = 1;
   localparam int CH_B   = 0;

   // Reset palette image: entry 0 is black, every other entry is full white,
   // so a plain index behaves like the old on/off switch colour.
   function automatic logic pal_reset_bit(input int unsigned idx);
      return (idx != 0);
   endfunction

endpackage

// File: rtl/color_mapper_blink_timer.sv
// Free-running blink timer: counts 0..BLINK_DIV-1 and flips the phase on each
// wrap, so the phase holds for exactly BLINK_DIV cycles.
module blink_timer #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst_n,
   output logic blink_phase
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             phase_q;

   // Counter wraps at LAST; the wrap edge is the only place the phase flips.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   assign blink_phase = phase_q;

endmodule

// File: rtl/color_mapper.sv
// Palette colour mapper: index -> writable RGB palette -> display mode -> channel
// mask, two registered stages, blanked output whenever no pixel is valid.
module color_mapper
   import color_pkg::*;
#(
   parameter int IDX_W     = 2,
   parameter int CH_W      = 8,
   parameter int BLINK_DIV = 25000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [IDX_W-1:0]  in_index,
   input  logic [1:0]        mode,
   input  logic [2:0]        sw,
   input  logic              pal_we,
   input  logic [IDX_W-1:0]  pal_addr,
   input  logic [3*CH_W-1:0] pal_data,
   output logic              out_valid,
   output logic [CH_W-1:0]   red_out,
   output logic [CH_W-1:0]   green_out,
   output logic [CH_W-1:0]   blue_out,
   output logic              blink_phase
);

   localparam int DEPTH = 2**IDX_W;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   rgb_t             pal_q [DEPTH];
   logic [2:1]       vld_pipe_q;   // [1] = stage 1, [2] = output stage
   logic [IDX_W-1:0] idx1_q;
   mode_e            mode1_q;
   rgb_t             pix;
   rgb_t             moded;
   rgb_t             out_d;
   rgb_t             out_q;
   logic             phase;

   blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
      .clk         (clk),
      .rst_n       (rst_n),
      .blink_phase (phase)
   );

   // Palette storage: one register per entry so each gets its own reset image.
   // A same-cycle read sees the pre-edge contents, giving old-value-on-collision.
   for (genvar e = 0; e < DEPTH; e++) begin : g_pal
      // Entry e: load from pal_data on a write that targets it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            pal_q[e] <= rgb_t'({(3*CH_W){pal_reset_bit(e)}});
         else if (pal_we && (pal_addr == IDX_W'(e)))
            pal_q[e] <= rgb_t'(pal_data);
      end
   end

   // Stage 1: capture the pixel with its mode so later mode changes don't touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         idx1_q     <= '0;
         mode1_q    <= MODE_DIRECT;
      end else begin
         vld_pipe_q <= {vld_pipe_q[1], in_valid};
         idx1_q     <= in_index;
         mode1_q    <= mode_e'(mode);
      end
   end

   // Stage 2 datapath: palette lookup, per-channel mode, then switch mask.
   always_comb begin
      pix   = pal_q[idx1_q];
      moded = pix;
      case (mode1_q)
         MODE_DIRECT: moded = pix;
         MODE_BLINK:  moded = phase ? '0 : pix;
         MODE_DIM: begin
            moded.r = pix.r >> 1;
            moded.g = pix.g >> 1;
            moded.b = pix.b >> 1;
         end
         MODE_INVERT: moded = ~pix;
         default:     moded = pix;
      endcase
      out_d = '0;
      if (vld_pipe_q[1]) begin
         out_d.r = sw[0] ? moded.r : '0;
         out_d.g = sw[1] ? moded.g : '0;
         out_d.b = sw[2] ? moded.b : '0;
      end
   end

   // Output register; a bubble in stage 2 registers black.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out_q <= '0;
      else
         out_q <= out_d;
   end

   assign out_valid   = vld_pipe_q[2];
   assign red_out     = out_q.r;
   assign green_out   = out_q.g;
   assign blue_out    = out_q.b;
   assign blink_phase = phase;

endmodule
